display_timing: RTL and testbench

DISPLAY_TIMING -- requirements
Module: display_timing

---
 rtl/display_timing.sv | 129 ++++++++++++
 tb/tb_display_timing.sv | 138 +++++++++++++
 2 files changed

// File: rtl/display_timing.sv
// rtl/display_timing.sv - VGA-style raster timing generator with registered sync/blanking outputs
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   horizSync    HSYNC, active low
//   vertSync     VSYNC, active low
//   videoOn      high inside the active picture area
//   pixelColumn  horizontal count, 0..H_TOTAL-1
//   pixelRow     vertical count, 0..V_TOTAL-1
//   pixelTick    one-clk pulse on the first clk of each pixel period
//   frameStart   one-clk pulse when the outputs first show (0,0) after a frame wrap

module display_timing #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       horizSync,
    output logic       vertSync,
    output logic       videoOn,
    output logic [9:0] pixelColumn,
    output logic [9:0] pixelRow,
    output logic       pixelTick,
    output logic       frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [2:0] DIV_LAST   = 3'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [2:0] div_cnt_q, div_cnt_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    // Set by the first pixel tick after reset; keeps frameStart quiet for the reset-exit frame.
    logic       started_q, started_d;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       pix_tick_q, pix_tick_d;
    logic       frame_start_q, frame_start_d;

    logic       tick;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? 3'd0 : div_cnt_q + 3'd1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        started_d = started_q | tick;

        // Line end and frame wrap resolve in the same clk, so no out-of-range count is ever held.
        if (tick) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end

        // Output decode of the current counters; registered below for one clk of latency.
        hsync_d       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
        vsync_d       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
        video_on_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        col_d         = h_cnt_q;
        row_d         = v_cnt_q;
        // divCnt == 0 marks the first clk a new hCount value is held.
        pix_tick_d    = (div_cnt_q == 3'd0);
        frame_start_d = started_q && (div_cnt_q == 3'd0) && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q     <= 3'd0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            started_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            pix_tick_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            started_q     <= started_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_tick_q    <= pix_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign horizSync   = hsync_q;
    assign vertSync    = vsync_q;
    assign videoOn     = video_on_q;
    assign pixelColumn = col_q;
    assign pixelRow    = row_q;
    assign pixelTick   = pix_tick_q;
    assign frameStart  = frame_start_q;

endmodule

// File: tb/tb_display_timing.sv
// tb/tb_display_timing.sv - directed self-checking bench for display_timing

module tb_display_timing;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic       a_hs, a_vs, a_vo, a_pt, a_fs;
    logic [9:0] a_col, a_row;
    logic       b_hs, b_vs, b_vo, b_pt, b_fs;
    logic [9:0] b_col, b_row;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_timing #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .horizSync(a_hs), .vertSync(a_vs),
        .videoOn(a_vo), .pixelColumn(a_col), .pixelRow(a_row),
        .pixelTick(a_pt), .frameStart(a_fs)
    );

    display_timing #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .horizSync(b_hs), .vertSync(b_vs),
        .videoOn(b_vo), .pixelColumn(b_col), .pixelRow(b_row),
        .pixelTick(b_pt), .frameStart(b_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string who, input logic hs, input logic vs, input logic vo,
                             input logic [9:0] col, input logic [9:0] row,
                             input logic pt, input logic fs);
        chk({who, ".rst.hs"}, 32'(hs), 32'd1);
        chk({who, ".rst.vs"}, 32'(vs), 32'd1);
        chk({who, ".rst.vo"}, 32'(vo), 32'd0);
        chk({who, ".rst.col"}, 32'(col), 32'd0);
        chk({who, ".rst.row"}, 32'(row), 32'd0);
        chk({who, ".rst.pt"}, 32'(pt), 32'd0);
        chk({who, ".rst.fs"}, 32'(fs), 32'd0);
    endtask

    // k = number of clk edges since reset release (k = 1 is the first edge with reset_n high).
    task automatic chk_model(input string who, input int div, input int k,
                             input logic hs, input logic vs, input logic vo,
                             input logic [9:0] col, input logic [9:0] row,
                             input logic pt, input logic fs);
        int c, p, col_e, row_e;
        c     = k - 1;
        p     = c / div;
        col_e = p % HT;
        row_e = (p / HT) % VT;
        chk({who, ".col"}, 32'(col), 32'(col_e));
        chk({who, ".row"}, 32'(row), 32'(row_e));
        chk({who, ".hs"}, 32'(hs), 32'(!(col_e >= HA + HF && col_e < HA + HF + HS)));
        chk({who, ".vs"}, 32'(vs), 32'(!(row_e >= VA + VF && row_e < VA + VF + VS)));
        chk({who, ".vo"}, 32'(vo), 32'(col_e < HA && row_e < VA));
        chk({who, ".pt"}, 32'(pt), 32'(c % div == 0));
        chk({who, ".fs"}, 32'(fs), 32'(c > 0 && c % div == 0 && p % (HT * VT) == 0));
    endtask

    initial begin
        int budget;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("a", a_hs, a_vs, a_vo, a_col, a_row, a_pt, a_fs);
        chk_reset("b", b_hs, b_vs, b_vo, b_col, b_row, b_pt, b_fs);

        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // First clk after reset release: (0,0) visible, tick, no frameStart.
        chk("a.exit.vo", 32'(a_vo), 32'd1);
        chk("a.exit.pt", 32'(a_pt), 32'd1);
        chk("a.exit.fs", 32'(a_fs), 32'd0);
        chk("a.exit.col", 32'(a_col), 32'd0);
        chk_model("a", 2, 1, a_hs, a_vs, a_vo, a_col, a_row, a_pt, a_fs);
        chk_model("b", 1, 1, b_hs, b_vs, b_vo, b_col, b_row, b_pt, b_fs);

        // Two full frames of dut_a (240 clks each) and four of dut_b, including wraps.
        for (int k = 2; k <= 490; k++) begin
            @(posedge clk);
            #1;
            chk_model("a", 2, k, a_hs, a_vs, a_vo, a_col, a_row, a_pt, a_fs);
            chk_model("b", 1, k, b_hs, b_vs, b_vo, b_col, b_row, b_pt, b_fs);
            if (k == 241) begin
                // Hand-computed frame wrap of dut_a: (14,7) -> (0,0) with frameStart.
                chk("a.wrap.fs", 32'(a_fs), 32'd1);
                chk("a.wrap.row", 32'(a_row), 32'd0);
            end
        end

        // Reset asserted mid-vsync (last vsync row) while hsync is low.
        budget = 0;
        while (!(a_row == 10'd6 && a_hs == 1'b0) && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("midsync.found", 32'(budget < 2000), 32'd1);
        chk("midsync.vs_low", 32'(a_vs), 32'd0);

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("a.mid", a_hs, a_vs, a_vo, a_col, a_row, a_pt, a_fs);

        reset_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            chk_model("a.re", 2, k, a_hs, a_vs, a_vo, a_col, a_row, a_pt, a_fs);
            chk_model("b.re", 1, k, b_hs, b_vs, b_vo, b_col, b_row, b_pt, b_fs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
